adder_wce_sweep_checker: RTL

Self-contained sweep engine for one approximate adder instance under characterisation. It drives every input vector onto the adder's pi bus, samples its po bus and computes the exact sum of the two operands. It reports the maximum absolute error, the number of vectors whose error exceeds the WCE bound, and the first violating vector. It sits on both sides of the combinational adder: upstream as the stimulus source and downstream as the consumer of po.

---
 rtl/adder_wce_sweep_checker.sv | 119 +++++++++++
 1 files changed

// File: rtl/adder_wce_sweep_checker.sv
// adder_wce_sweep_checker: exhaustive sweep of an approximate adder, tracking worst-case error against WCE.
// Define ADDER_WCE_STOP_ON_FAIL_EN to end the sweep at the first violating vector.
module adder_wce_sweep_checker #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 3,
    parameter int WCE    = 2,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  pi_out,
    input  logic [N_OUT-1:0] po_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_OUT:0]   max_err,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_valid
);
    localparam int H = N_IN / 2;
`ifdef ADDER_WCE_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    localparam logic [N_OUT:0]  WCE_L    = (N_OUT+1)'(WCE);
    localparam logic [4:0]      SETTLE_L = 5'(SETTLE);
    localparam logic [N_IN-1:0] LAST     = '1;

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, FIN} state_t;

    state_t          state_q;
    logic [N_IN-1:0] vec_q, pi_q, ffv_q;
    logic [3:0]      cnt_q;
    logic            busy_q, done_q, pass_q, ffval_q;
    logic [N_OUT:0]  max_q;
    logic [N_IN:0]   errc_q;
    logic [N_OUT-1:0] exact_d;
    logic [N_OUT:0]  err_d;
    logic            viol_d;

    always_comb begin
        exact_d = N_OUT'(vec_q[N_IN-1:H]) + N_OUT'(vec_q[H-1:0]);
        err_d   = (po_in >= exact_d) ? {1'b0, po_in} - {1'b0, exact_d}
                                     : {1'b0, exact_d} - {1'b0, po_in};
        viol_d  = err_d > WCE_L;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            pi_q    <= '0;
            ffv_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b1;
            ffval_q <= 1'b0;
            max_q   <= '0;
            errc_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= DRIVE;
                    vec_q   <= '0;
                    busy_q  <= 1'b1;
                    pass_q  <= 1'b1;
                    max_q   <= '0;
                    errc_q  <= '0;
                    ffv_q   <= '0;
                    ffval_q <= 1'b0;
                end
                DRIVE: begin
                    pi_q    <= vec_q;
                    cnt_q   <= '0;
                    state_q <= (SETTLE == 0) ? CHECK : WAIT;
                end
                WAIT: begin
                    if ({1'b0, cnt_q} + 5'd1 == SETTLE_L) state_q <= CHECK;
                    else cnt_q <= cnt_q + 4'd1;
                end
                CHECK: begin
                    if (err_d > max_q) max_q <= err_d;
                    if (viol_d) begin
                        errc_q <= errc_q + (N_IN+1)'(1);
                        pass_q <= 1'b0;
                        if (!ffval_q) begin
                            ffv_q   <= vec_q;
                            ffval_q <= 1'b1;
                        end
                    end
                    if (vec_q == LAST || (STOP && viol_d)) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        vec_q   <= vec_q + N_IN'(1);
                        state_q <= DRIVE;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pi_out           = pi_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign max_err          = max_q;
    assign err_count        = errc_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffval_q;
endmodule
